// File: rtl/encoder_pkg.sv
// Shared types and constants for the 8-to-3 request encoder.
// Holds the FSM state enum, widths and a one-hot helper.
package encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_e;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [CODE_W-1:0] c
  );
    return N_REQ'(1) << c;
  endfunction

endpackage

// File: rtl/pri_enc_8to3.sv
// Fixed-priority encoder: highest set index wins.
// Ports: vec_i request vector, idx_o winning index, any_o any bit set.
module pri_enc_8to3
  import encoder_pkg::*;
(
  input  logic [N_REQ-1:0]  vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  // Ascending scan so the last (highest) set bit overrides.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec_i[i]) idx_o = CODE_W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/req_encoder_8to3.sv
// Sticky request collector presenting one source index per handshake.
// Ports: clk, rst, EN, req[7:0], ack in; code, valid, pending, ovf out.
module req_encoder_8to3
  import encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending,
  output logic              ovf
);

  enc_state_e        state_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic [N_REQ-1:0]  pending_q;
  logic              ovf_q;

  logic [N_REQ-1:0]  clr_mask;
  logic [N_REQ-1:0]  pending_d;
  logic              ovf_d;
  logic [CODE_W-1:0] win_idx;
  logic              win_any;

  // Only an accepted presentation clears its bit.
  assign clr_mask  = (valid_q && ack) ? onehot(code_q) : '0;
  // Set wins over clear.
  assign pending_d = (pending_q & ~clr_mask) | req;
  // A new event on a bit still pending (and not retiring) is lost.
  assign ovf_d     = ovf_q | (|(req & pending_q & ~clr_mask));

  pri_enc_8to3 u_pri (
    .vec_i (pending_q),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else if (!EN) begin
      // Withdraw without clearing; re-presented once enabled.
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      unique case (state_q)
        IDLE: begin
          if (win_any) begin
            state_q <= PRESENT;
            code_q  <= win_idx;
            valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          if (ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Directed self-checking bench for req_encoder_8to3.
// Drives #1 after each rising edge and checks there.
module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       EN;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       ovf;

  int n_chk = 0;
  int n_err = 0;

  req_encoder_8to3 dut (
    .clk     (clk),
    .rst     (rst),
    .EN      (EN),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(
    input string      tag,
    input logic       v,
    input logic [2:0] c,
    input logic [7:0] p,
    input logic       o
  );
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".code"}, 32'(code), 32'(c));
    check({tag, ".pend"}, 32'(pending), 32'(p));
    check({tag, ".ovf"}, 32'(ovf), 32'(o));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    EN  = 1'b0;
    req = '0;
    ack = 1'b0;
    #12;
    chk_all("rst", 0, 0, 8'h00, 0);
    tick();
    rst = 1'b0;

    // single request, two-edge latency
    EN  = 1'b1;
    req = 8'h04;
    tick();
    req = '0;
    chk_all("s1a", 0, 0, 8'h04, 0);
    tick();
    chk_all("s1b", 1, 2, 8'h04, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("s1c", 0, 2, 8'h00, 0);

    // priority: 7 before 0, IDLE gap
    req = 8'h81;
    tick();
    req = '0;
    tick();
    chk_all("s2a", 1, 7, 8'h81, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("s2b", 0, 7, 8'h01, 0);
    tick();
    chk_all("s2c", 1, 0, 8'h01, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("s2d", 0, 0, 8'h00, 0);
    tick();

    // presented code stable vs higher priority arrival
    req = 8'h08;
    tick();
    req = '0;
    tick();
    chk_all("s3a", 1, 3, 8'h08, 0);
    req = 8'h40;
    tick();
    req = '0;
    chk_all("s3b", 1, 3, 8'h48, 0);
    tick();
    chk_all("s3c", 1, 3, 8'h48, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("s3d", 0, 3, 8'h40, 0);
    tick();
    chk_all("s3e", 1, 6, 8'h40, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();

    // EN low withdraws, ignores req/ack
    req = 8'h10;
    tick();
    req = '0;
    tick();
    chk_all("s5a", 1, 4, 8'h10, 0);
    EN  = 1'b0;
    req = 8'hFF;
    ack = 1'b1;
    tick();
    chk_all("s5b", 0, 4, 8'h10, 0);
    tick();
    chk_all("s5c", 0, 4, 8'h10, 0);
    EN  = 1'b1;
    req = '0;
    ack = 1'b0;
    tick();
    chk_all("s5d", 1, 4, 8'h10, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("s5e", 0, 4, 8'h00, 0);

    // ack while idle has no effect
    ack = 1'b1;
    req = 8'h02;
    tick();
    ack = 1'b0;
    req = '0;
    chk_all("s7a", 0, 4, 8'h02, 0);
    tick();
    chk_all("s7b", 1, 1, 8'h02, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();

    // set wins over clear, then overflow
    req = 8'h20;
    tick();
    req = '0;
    tick();
    chk_all("s4a", 1, 5, 8'h20, 0);
    req = 8'h20;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("s4b", 0, 5, 8'h20, 0);
    tick();
    req = '0;
    chk_all("s4c", 1, 5, 8'h20, 1);

    // async reset mid-handshake
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req = 8'h3C;
    tick();
    req = '0;
    tick();
    chk_all("s6a", 1, 5, 8'h3C, 0);
    #3;
    rst = 1'b1;
    #1;
    chk_all("s6b", 0, 0, 8'h00, 0);
    #2;
    rst = 1'b0;
    req = 8'h01;
    tick();
    req = '0;
    chk_all("s6c", 0, 0, 8'h01, 0);
    tick();
    chk_all("s6d", 1, 0, 8'h01, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/req_encoder_8to3.md
REQ_ENCODER_8TO3 -- requirements
Module: req_encoder_8to3

Interface
REQ-001 The module SHALL have no parameters; widths are fixed (8 request lines, 3-bit code).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 EN  input  1  block enable; low = capture and presentation suspended.
REQ-005 req  input  8  request lines; bit i high for one or more cycles = event on source i.
REQ-006 ack  input  1  consumer accepts the presented code; meaningful only while valid=1.
REQ-007 code  output  3  registered index of the presented source.
REQ-008 valid  output  1  registered; code is meaningful.
REQ-009 pending  output  8  registered sticky pending vector.
REQ-010 ovf  output  1  registered sticky overflow flag.

Function
REQ-011 Reset values SHALL be code=3'd0, valid=0, pending=8'h00, ovf=0, FSM=IDLE.
REQ-012 While EN=1, each edge SHALL compute pending_next = (pending & ~clr_mask) | req, where clr_mask = one-hot(code) if valid&ack, else 8'h00.
REQ-013 Set SHALL win over clear: if req[code] is high in the ack cycle, pending[code] stays 1.
REQ-014 ovf SHALL set on any edge where EN=1, req[i]=1 and pending[i]=1 and bit i is not being cleared in that cycle; ovf clears only on reset.
REQ-015 Priority SHALL be fixed: the highest set index of pending wins (bit 7 highest, bit 0 lowest).
REQ-016 FSM states SHALL be IDLE and PRESENT.
REQ-017 IDLE -> PRESENT when EN=1 and pending != 0; on that edge code is loaded with the winning index and valid is set to 1.
REQ-018 PRESENT -> IDLE on an edge with ack=1; valid is 0 after that edge and code holds its last value.
REQ-019 In PRESENT with ack=0, code and valid SHALL stay stable even if a higher-priority bit becomes pending.
REQ-020 Latency: req[i] sampled at edge k (FSM idle) SHALL give valid=1 with code=i after edge k+1.
REQ-021 Throughput SHALL be at most one code per two cycles; the FSM always passes through IDLE for one cycle after an ack.
REQ-022 When EN=0: req is ignored, pending and ovf hold, and ack is ignored. A PRESENT FSM SHALL go to IDLE with valid=0 without clearing pending, so the code is re-presented once EN returns.
REQ-023 If ack=1 while valid=0, it SHALL have no effect.

Reset
REQ-024 Asserting rst SHALL force all outputs and the FSM to their REQ-011 values immediately, without waiting for a clock edge, including mid-handshake.
REQ-025 Capture SHALL resume on the first rising edge after rst is released, with no request lost from that edge onward.

Structure
REQ-026 A shared package encoder_pkg SHALL hold the FSM state enum (IDLE, PRESENT), N_REQ=8 and CODE_W=3.
REQ-027 The combinational highest-index-wins function SHALL be a sub-module pri_enc_8to3 (in: 8-bit vector; out: 3-bit index plus any flag).

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset, then EN=1, req=8'h04 for 1 cycle -> valid=1, code=2 two edges later; ack=1 -> valid=0, pending=8'h00.
- req=8'h81 in one cycle -> code=7 first; after ack and one IDLE cycle, code=0, pending=8'h01.
- In PRESENT with code=3 and ack=0, req=8'h40 -> code stays 3; after ack, code=6 is presented next.
- req[5] held high during the ack of code=5 -> pending[5] stays 1, code=5 is re-presented, and ovf=1 on later held cycles.
- EN=0 while valid=1 -> valid=0, pending unchanged, req=8'hFF ignored; EN=1 -> the same code is re-presented.
- rst pulse between clock edges while valid=1, pending=8'h3C -> all outputs are zero before the next edge.
